// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared types and defaults for the CPU clock-enable scheduler.
package cpu_clk_ctrl_pkg;

  // Scheduler states; 2'b11 is illegal and recovers to ST_STEP.
  typedef enum logic [1:0] {
    ST_STEP   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  // Debounce window: 10 ms at 100 MHz.
  localparam int unsigned DB_CYCLES_DEF = 1000000;

endpackage

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// Button debouncer: the clean level follows the (already synchronized) raw
// input only after raw has disagreed with it for CYCLES consecutive clocks.
module btn_debounce #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;

  // Count consecutive disagreement; any agreement restarts the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      clean <= 1'b0;
    end else if (raw == clean) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      clean <= raw;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Clock-enable scheduler for the multicycle MIPS core.
// Optional step-button debouncing is enabled by defining CPU_CLK_CTRL_DEBOUNCE_EN.
module cpu_clk_ctrl
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk_100mhz,
  input  logic             rst_n,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt,
  input  logic [DIV_W-1:0] div_ratio,
  output logic             cpu_ce,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] ce_count
);

  logic             run_s1, run_s;
  logic             btn_s1, btn_s;
  logic             btn_lvl, btn_prev, step_evt;
  state_t           st, st_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic             ce_nxt;

  // A debounce window below two clocks leaves no room for a counter.
  if (DB_CYCLES < 2) begin : g_db_cycles_check
    $error("cpu_clk_ctrl: DB_CYCLES must be at least 2");
  end

  // Two-flop synchronizers for the asynchronous board controls.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      run_s1 <= 1'b0;
      run_s  <= 1'b0;
      btn_s1 <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      run_s1 <= run_sw;
      run_s  <= run_s1;
      btn_s1 <= step_btn;
      btn_s  <= btn_s1;
    end
  end

`ifdef CPU_CLK_CTRL_DEBOUNCE_EN
  btn_debounce #(.CYCLES(DB_CYCLES)) u_debounce (
    .clk   (clk_100mhz),
    .rst_n (rst_n),
    .raw   (btn_s),
    .clean (btn_lvl)
  );
`else
  assign btn_lvl = btn_s;
`endif

  // Previous clean button level for rising-edge detection.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) btn_prev <= 1'b0;
    else        btn_prev <= btn_lvl;
  end

  assign step_evt = btn_lvl & ~btn_prev;

  // State register.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) st <= ST_STEP;
    else        st <= st_nxt;
  end

  // Next-state logic; priority halt > run level > step event.
  always_comb begin
    st_nxt = st;
    case (st)
      ST_STEP: begin
        if (halt)       st_nxt = ST_HALTED;
        else if (run_s) st_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (halt)        st_nxt = ST_HALTED;
        else if (!run_s) st_nxt = ST_STEP;
      end
      ST_HALTED: begin
        if (step_evt && !halt) st_nxt = ST_STEP;
      end
      default: st_nxt = ST_STEP;
    endcase
  end

  // Enable decision and divider update for the coming edge.
  always_comb begin
    ce_nxt  = 1'b0;
    div_nxt = div_cnt;
    case (st)
      ST_STEP: begin
        if (halt) begin
          div_nxt = div_cnt;
        end else if (run_s) begin
          div_nxt = '0;
        end else if (step_evt) begin
          ce_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        if (halt) begin
          div_nxt = div_cnt;
        end else if (!run_s) begin
          div_nxt = '0;
        end else if (div_cnt >= div_ratio) begin
          ce_nxt  = 1'b1;
          div_nxt = '0;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      ST_HALTED: ce_nxt = 1'b0;
      default:   div_nxt = '0;
    endcase
  end

  // Registered outputs; ce_count advances together with each issued enable.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      cpu_ce   <= 1'b0;
      div_cnt  <= '0;
      ce_count <= '0;
    end else begin
      cpu_ce   <= ce_nxt;
      div_cnt  <= div_nxt;
      ce_count <= ce_count + CNT_W'(ce_nxt);
    end
  end

  assign state = st;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed self-checking bench for cpu_clk_ctrl.
module tb_cpu_clk_ctrl;

  localparam int unsigned DB = 16;
`ifdef CPU_CLK_CTRL_DEBOUNCE_EN
  localparam int unsigned LAT = 3 + DB;
`else
  localparam int unsigned LAT = 3;
`endif
  localparam int unsigned HOLD = LAT + 2;
  localparam int unsigned GAP  = LAT + 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_sw = 1'b0;
  logic        step_btn = 1'b0;
  logic        halt = 1'b0;
  logic [7:0]  div_ratio = '0;
  logic        cpu_ce;
  logic [1:0]  state;
  logic [31:0] ce_count;

  int checks = 0;
  int errors = 0;

  cpu_clk_ctrl #(.DIV_W(8), .DB_CYCLES(DB), .CNT_W(32)) dut (
    .clk_100mhz (clk),
    .rst_n      (rst_n),
    .run_sw     (run_sw),
    .step_btn   (step_btn),
    .halt       (halt),
    .div_ratio  (div_ratio),
    .cpu_ce     (cpu_ce),
    .state      (state),
    .ce_count   (ce_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Press and release the step button, checking the enable lands LAT edges later.
  task automatic press(input logic exp_ce);
    step_btn = 1'b1;
    for (int i = 1; i <= int'(HOLD); i++) begin
      tick(1);
      chk("press_ce", {31'd0, cpu_ce}, {31'd0, (i == int'(LAT)) ? exp_ce : 1'b0});
    end
    step_btn = 1'b0;
    for (int i = 0; i < int'(GAP); i++) begin
      tick(1);
      chk("release_ce", {31'd0, cpu_ce}, 32'd0);
    end
  endtask

  int pulses;

  initial begin
    #1;
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_ce", {31'd0, cpu_ce}, 32'd0);
    chk("rst_count", ce_count, 32'd0);
    tick(2);
    rst_n = 1'b1;

    // Free-run at ratio 3.
    run_sw = 1'b1;
    div_ratio = 8'd3;
    tick(2);
    chk("run_entry_early", {30'd0, state}, 32'd0);
    tick(1);
    chk("run_entry", {30'd0, state}, 32'd1);
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      chk("run_r3_ce", {31'd0, cpu_ce}, {31'd0, (i % 4 == 0)});
    end
    chk("run_r3_count", ce_count, 32'd10);

    // Ratio 0: enable held high.
    div_ratio = 8'd0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("run_r0_ce", {31'd0, cpu_ce}, 32'd1);
    end
    chk("run_r0_count", ce_count, 32'd15);

    // One-cycle halt.
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    chk("halt_state", {30'd0, state}, 32'd2);
    chk("halt_ce", {31'd0, cpu_ce}, 32'd0);
    chk("halt_count", ce_count, 32'd15);
    run_sw = 1'b0;
    tick(4);
    chk("halted_hold", {30'd0, state}, 32'd2);
    chk("halted_count", ce_count, 32'd15);

    // Press releases HALTED without an enable; next press steps once.
    press(1'b0);
    chk("unhalt_state", {30'd0, state}, 32'd0);
    chk("unhalt_count", ce_count, 32'd15);
    press(1'b1);
    chk("step_after_halt", ce_count, 32'd16);

    // Three step pulses.
    press(1'b1);
    press(1'b1);
    press(1'b1);
    chk("step3_count", ce_count, 32'd19);
    chk("step3_state", {30'd0, state}, 32'd0);

`ifdef CPU_CLK_CTRL_DEBOUNCE_EN
    // Bouncy press then stable high: exactly one enable.
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step_btn = (i % 2 == 0);
      tick(1);
      pulses += int'(cpu_ce);
    end
    step_btn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      pulses += int'(cpu_ce);
    end
    step_btn = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      pulses += int'(cpu_ce);
    end
    chk("db_bounce_pulses", pulses, 32'd1);
    // Ten-clock glitch alone: no enable.
    pulses = 0;
    step_btn = 1'b1;
    tick(10);
    step_btn = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      pulses += int'(cpu_ce);
    end
    chk("db_glitch_pulses", pulses, 32'd0);
    chk("db_count", ce_count, 32'd20);
`endif

    // Fresh reset, then lower the ratio mid-count.
    rst_n = 1'b0;
    run_sw = 1'b1;
    div_ratio = 8'd9;
    #1;
    chk("rst2_count", ce_count, 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    chk("rst2_run", {30'd0, state}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("r9_ce", {31'd0, cpu_ce}, 32'd0);
    end
    div_ratio = 8'd2;
    tick(1);
    chk("ratio_drop_ce", {31'd0, cpu_ce}, 32'd1);
    tick(1);
    chk("r2_ce_a", {31'd0, cpu_ce}, 32'd0);
    tick(1);
    chk("r2_ce_b", {31'd0, cpu_ce}, 32'd0);
    tick(1);
    chk("r2_ce_c", {31'd0, cpu_ce}, 32'd1);
    chk("r2_count", ce_count, 32'd2);

    // Asynchronous reset mid-pulse.
    rst_n = 1'b0;
    #1;
    chk("async_ce", {31'd0, cpu_ce}, 32'd0);
    chk("async_count", ce_count, 32'd0);
    chk("async_state", {30'd0, state}, 32'd0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_clk_ctrl.md
# cpu_clk_ctrl

Clock-enable scheduler for the multicycle MIPS core. It runs in the 100 MHz domain produced by the board clock divider and issues a single-cycle `cpu_ce` pulse that gates every CPU register. The pulse rate is selected by board controls: free-run at a programmable division ratio, single-step from a pushbutton, or halted on CPU request. It also keeps a running count of issued enables for the debug display.

## Interface
- `DIV_W`, 8: width of `div_ratio`.
- `DB_CYCLES`, 1000000: debounce stability window in clocks (10 ms at 100 MHz).
- `CNT_W`, 32: width of `ce_count`.

- `clk_100mhz` in 1: the single clock. All logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `run_sw` in 1: raw slide switch, asynchronous. 1 = free-run, 0 = step mode.
- `step_btn` in 1: raw pushbutton, asynchronous, active-high.
- `halt` in 1: halt request from the CPU, synchronous to `clk_100mhz`, level.
- `div_ratio` in DIV_W: in RUN, one enable is issued every `div_ratio+1` clocks.
- `cpu_ce` out 1: registered enable pulse. Reset value 0.
- `state` out 2: current state, registered. Reset value STEP (2'b00).
- `ce_count` out CNT_W: enables issued since reset. Reset value 0.

## Operation
- `run_sw` and `step_btn` each pass through a 2-flop synchronizer. The synchronizer flops reset to 0.
- `step_btn` is then debounced when that feature is enabled (see Configuration).
- A rising-edge detector on the clean button level produces `step_evt`, one cycle wide.
- States and encoding:
  - STEP = 2'b00
  - RUN = 2'b01
  - HALTED = 2'b10
  - 2'b11 is illegal and recovers to STEP on the next clock, with no `cpu_ce`.
- Priority within a cycle: `halt` > `run_sw` level > `step_evt`.
- STEP state:
  - `halt` → HALTED.
  - Else `run_s` = 1 → RUN, with `div_cnt` cleared.
  - Else `step_evt` → `cpu_ce` = 1 for exactly one cycle.
- RUN state:
  - `halt` → HALTED, and any enable due that cycle is suppressed.
  - Else `run_s` = 0 → STEP, with `div_cnt` cleared and no enable.
  - Else, if `div_cnt >= div_ratio`: `cpu_ce` = 1 and `div_cnt` ← 0. Otherwise `div_cnt` increments.
  - Using `>=` means that lowering `div_ratio` mid-count fires the enable on the next cycle.
  - `div_ratio` = 0 gives `cpu_ce` high continuously.
- HALTED state:
  - No enables are issued.
  - `step_evt` with `halt` = 0 → STEP. That press is consumed and produces no enable.
  - `run_sw` is ignored in HALTED.
- `step_evt` in RUN state is discarded.
- `ce_count` increments on every cycle with `cpu_ce` = 1 and wraps modulo 2^CNT_W.
- `div_cnt` is DIV_W bits wide and resets to 0.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- `cpu_ce` rises on the edge after the decision cycle.
- Without debounce, a raw button rising edge stable before clock edge k produces `cpu_ce` high after edge k+3 for one cycle (2 synchronizer stages + 1 output register).
- With debounce, that latency grows by `DB_CYCLES`.
- A `run_sw` toggle changes `state` after edge k+3.
- `halt` asserted in cycle n:
  - `state` = HALTED after the edge ending cycle n.
  - No `cpu_ce` appears in cycle n+1.
- In RUN with constant `div_ratio` = R, the enable period is exactly R+1 clocks. The first enable comes R+1 clocks after entering RUN.
- Reset mid-operation clears state, counters, synchronizers and the debouncer immediately and asynchronously. `cpu_ce` drops within the reset.

## Configuration
- `CPU_CLK_CTRL_DEBOUNCE_EN` defined:
  - `step_btn` is debounced by `btn_debounce`.
  - The stable level updates only after the synchronized input differs from it for `DB_CYCLES` consecutive clocks.
  - Any agreement during the window restarts the count.
- Not defined:
  - The synchronized level feeds the edge detector directly.
  - `DB_CYCLES` is unused.
  - Intended for simulation and testbench speed.

## Structure
- Shared package `cpu_clk_ctrl_pkg` holds:
  - the state typedef with its three encodings;
  - the `DB_CYCLES` default constant.
- Sub-module `btn_debounce` (parameter `CYCLES`; ports clk, rst_n, raw in, clean out):
  - instantiated only under the macro;
  - contains its own counter of width $clog2(CYCLES).

## Test plan
- Reset, then `run_sw` = 1, `div_ratio` = 3 → `state` RUN after 3 edges. `cpu_ce` is high 1 cycle in every 4. `ce_count` = 10 after 40 clocks of RUN.
- RUN with `div_ratio` = 0 → `cpu_ce` held high. Then `halt` = 1 for one cycle → `cpu_ce` low the following cycle and `state` = HALTED. `ce_count` freezes.
- STEP mode with macro off: three clean button pulses 20 clocks apart → exactly 3 single-cycle `cpu_ce` pulses, each 3 edges after its press. `ce_count` = 3.
- Macro on with `DB_CYCLES` = 16: a button with 5-clock bounce glitches, then stable high for 16 clocks → exactly one `cpu_ce`. A 10-clock glitch alone → none.
- HALTED: press the step button with `halt` = 0 → `state` STEP and no `cpu_ce`. The next press → one `cpu_ce`.
- RUN with `div_cnt` at 6 and `div_ratio` changed from 9 to 2 → `cpu_ce` on the next cycle, then a period of 3. Assert `rst_n` low mid-pulse → `cpu_ce`, `ce_count` and `state` return to 0 immediately.
